xsleena_tile_fetch: RTL and testbench
=====================================

XSLEENA_TILE_FETCH -- requirements
Module: xsleena_tile_fetch

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CODE_W, 10, tile code width.
REQ-002 COLOR_W, 3, palette/colour attribute width; CODE_W+COLOR_W SHALL be <= 15 (static check).
REQ-003 PIX_W, 4, bits per pixel; fixed at 4 in this generation (static check).
REQ-004 ROM_AW, 14, ROM word address width; SHALL equal CODE_W+4 (static check).
REQ-005 Ports SHALL be (name, direction, width, meaning): clk, in, 1, master clock; all logic on its rising edge.
REQ-006 RSTn, in, 1, synchronous active-low reset.
REQ-007 pix_cen, in, 1, pixel clock enable, one clk cycle per pixel.
REQ-008 tile_start, in, 1, first pixel of the next 8-pixel tile; meaningful only when pix_cen=1.
REQ-009 vfine, in, 3, row within tile for the fetch being started.
REQ-010 flip_x, in, 1, global horizontal flip.
REQ-011 map_rd, out, 1, one-cycle tilemap SRAM read strobe.
REQ-012 map_entry, in, 16, tilemap word, valid exactly 1 clk after map_rd: [CODE_W-1:0] code, next COLOR_W bits colour, [15] per-tile flip.
REQ-013 ROM_req, out, 1, level request; ROM_addr, out, ROM_AW, word address; ROM_ack, in, 1, one-cycle pulse; ROM_data, in, 16, valid while ROM_ack=1.
REQ-014 pix, out, COLOR_W+4, {colour, pixel}; underrun, out, 1, sticky late-fetch flag.

Function
REQ-015 FSM states SHALL be IDLE, MAPRD, MAPWAIT, REQ0, REQ1, DONE.
REQ-016 Fetch start: on pix_cen&tile_start, latch vfine, assert map_rd for 1 cycle, enter MAPRD, then MAPWAIT; capture map_entry in MAPWAIT.
REQ-017 Base address {code,vfine}; word n address SHALL be {code,vfine,n}, n in {0,1}.
REQ-018 Cache: if base equals last completed base and cache valid, SHALL skip REQ0/REQ1, reuse cached words, go DONE, no ROM_req.
REQ-019 Otherwise REQ0 then REQ1: ROM_req=1 and ROM_addr stable until the ROM_ack cycle; capture ROM_data on ack; ROM_req SHALL deassert the cycle after ack.
REQ-020 At most one request outstanding; ROM_req SHALL never drop before ack.
REQ-021 After REQ1 ack: store words and base in cache, cache valid=1, enter DONE.
REQ-022 Double buffer: fetch writes back buffer; front buffer drives output.
REQ-023 On pix_cen&tile_start with DONE: back buffer -> front, pix SHALL show pixel 0 of the new tile on the same edge.
REQ-024 Pixel order unflipped: p0=word0[15:12], p1=word0[11:8], ..., p4=word1[15:12], ..., p7=word1[3:0]; flip = entry[15] XOR latched flip_x reverses order (p0=word1[3:0]).
REQ-025 Each other pix_cen SHALL advance one pixel; after p7, SHALL hold {colour,0} until next tile_start.
REQ-026 Underrun: tile_start while not DONE SHALL load transparent front ({0,0} for all pixels), set underrun=1 (cleared only by reset), discard the in-flight fetch.
REQ-027 If underrun occurs with ROM_req high, FSM SHALL complete that handshake, discard the data, not update the cache, then begin the new fetch (map_rd) on the cycle after ack.
REQ-028 tile_start while IDLE or DONE SHALL start the new fetch immediately.
REQ-029 Fetch sequence SHALL ignore pix_cen; only tile_start is pixel-qualified.
REQ-030 ROM_ack outside REQ0/REQ1 SHALL be ignored.

Reset
REQ-031 RSTn=0 at clk edge SHALL force: state IDLE, map_rd=0, ROM_req=0, ROM_addr=0, pix=0, underrun=0, cache valid=0, front/back buffers 0.
REQ-032 Reset mid-handshake SHALL drop ROM_req next edge; the memory controller is reset in the same domain.
REQ-033 After reset release, pix SHALL stay 0 until the first completed fetch is loaded at a tile_start.

Verification
REQ-034 Normal: entry 0x2155 (code 0x155, colour 0), vfine=3, ack 4 cycles after each req -> ROM_addr 0x1556 then 0x1557; next tile_start outputs word0=0x1234 nibbles 1,2,3,4 then word1 nibbles.
REQ-035 Flip: same data, entry bit15=1, flip_x=0 -> pixels from word1[3:0] backwards to word0[15:12]; flip_x=1 also -> unflipped order.
REQ-036 Cache hit: two consecutive tiles with identical code/vfine -> second tile has no ROM_req, identical pixels, DONE within 3 cycles of tile_start.
REQ-037 Underrun: ack withheld past the next tile_start -> pix=0 for 8 pixels, underrun=1, ROM_req held until ack, map_rd on the following cycle, cache unchanged.
REQ-038 Reset during REQ1 with ROM_req=1 -> ROM_req=0, pix=0, underrun=0 next edge; first post-reset same-code tile issues ROM requests (cache invalid).
REQ-039 Colour: entry colour=5, COLOR_W=3 -> pix[6:4]=5 for all 8 pixels; at PIX_W!=4 or ROM_AW!=CODE_W+4 elaboration SHALL fail.

Source files
------------

// File: rtl/xsleena_tile_fetch_if.sv
// ---------------------------------------------------------------------------
// xsleena_tile_fetch_if
//   Memory-side bundle of the tile fetcher: tilemap SRAM read port and the
//   character ROM request/acknowledge handshake.
//
//   map_rd     one-cycle tilemap read strobe (fetcher -> SRAM)
//   map_entry  tilemap word, valid the clk after map_rd (SRAM -> fetcher)
//   ROM_req    level request, held until ROM_ack (fetcher -> ROM ctrl)
//   ROM_addr   ROM word address, stable while ROM_req=1
//   ROM_ack    one-cycle acknowledge pulse (ROM ctrl -> fetcher)
//   ROM_data   ROM word, valid while ROM_ack=1
//
//   master: the fetcher.  slave: the memory side.
// ---------------------------------------------------------------------------
interface xsleena_tile_fetch_if #(
    parameter int ROM_AW = 14
);
    logic              map_rd;
    logic [15:0]       map_entry;
    logic              ROM_req;
    logic [ROM_AW-1:0] ROM_addr;
    logic              ROM_ack;
    logic [15:0]       ROM_data;

    modport master (
        output map_rd, ROM_req, ROM_addr,
        input  map_entry, ROM_ack, ROM_data
    );

    modport slave (
        input  map_rd, ROM_req, ROM_addr,
        output map_entry, ROM_ack, ROM_data
    );
endinterface

// File: rtl/xsleena_tile_fetch.sv
// ---------------------------------------------------------------------------
// xsleena_tile_fetch
//   Fetches one 8-pixel, 4bpp tile row per tile: reads the tilemap entry,
//   pulls two 16-bit words from the character ROM (or reuses them from a
//   one-entry cache when the code/row repeats) into a back buffer, and on the
//   next tile_start swaps it into the front buffer that drives pix.
//   A tile_start that finds the fetch unfinished shows a transparent tile and
//   raises the sticky underrun flag.
//
//   clk        master clock
//   RSTn       synchronous active-low reset
//   pix_cen    pixel clock enable (one clk per pixel)
//   tile_start first pixel of next tile (qualified by pix_cen)
//   vfine      row within tile for the fetch being started
//   flip_x     global horizontal flip
//   mem        tilemap / ROM bus (master side)
//   pix        {colour, pixel}
//   underrun   sticky late-fetch flag
// ---------------------------------------------------------------------------
module xsleena_tile_fetch #(
    parameter int CODE_W  = 10,
    parameter int COLOR_W = 3,
    parameter int PIX_W   = 4,
    parameter int ROM_AW  = 14
) (
    input  logic                       clk,
    input  logic                       RSTn,
    input  logic                       pix_cen,
    input  logic                       tile_start,
    input  logic [2:0]                 vfine,
    input  logic                       flip_x,
    xsleena_tile_fetch_if.master       mem,
    output logic [COLOR_W+PIX_W-1:0]   pix,
    output logic                       underrun
);

    localparam int BASE_W = CODE_W + 3;

    // Elaboration-time parameter sanity checks.
    if (PIX_W != 4) begin : g_pix_w_check
        $error("xsleena_tile_fetch: PIX_W must be 4");
    end
    if (ROM_AW != CODE_W + 4) begin : g_rom_aw_check
        $error("xsleena_tile_fetch: ROM_AW must equal CODE_W+4");
    end
    if (CODE_W + COLOR_W > 15) begin : g_entry_check
        $error("xsleena_tile_fetch: CODE_W+COLOR_W must be <= 15");
    end

    typedef enum logic [2:0] {IDLE, MAPRD, MAPWAIT, REQ0, REQ1, DONE} state_t;

    state_t              state_reg;
    logic                map_rd_reg;
    logic                rom_req_reg;
    logic [ROM_AW-1:0]   rom_addr_reg;
    logic [2:0]          vfine_reg;
    logic                flip_x_reg;
    logic                drain_reg;      // in-flight handshake belongs to an abandoned fetch
    logic [CODE_W-1:0]   code_reg;
    logic [COLOR_W-1:0]  colour_reg;
    logic                flip_reg;
    logic [15:0]         word0_reg;

    logic                cache_valid_reg;
    logic [BASE_W-1:0]   cache_base_reg;
    logic [31:0]         cache_words_reg;

    logic [31:0]         back_words_reg;
    logic [COLOR_W-1:0]  back_colour_reg;
    logic                back_flip_reg;
    logic [31:0]         front_words_reg;
    logic [COLOR_W-1:0]  front_colour_reg;
    logic                front_flip_reg;
    logic [3:0]          pix_idx_reg;    // next pixel to show; 8 = tile exhausted
    logic [COLOR_W+PIX_W-1:0] pix_reg;
    logic                underrun_reg;

    logic                tile_go;
    logic                in_handshake;
    logic                start_now;
    logic [CODE_W-1:0]   entry_code;
    logic [COLOR_W-1:0]  entry_colour;
    logic                entry_flip;
    logic                cache_hit;
    logic [PIX_W-1:0]    back_p0;
    logic                unused_entry_bits;

    assign tile_go      = pix_cen & tile_start;
    assign in_handshake = ((state_reg == REQ0) || (state_reg == REQ1)) && rom_req_reg;
    // A pending ROM handshake must finish first; otherwise a new tile starts
    // its fetch straight away, abandoning whatever was in progress.
    assign start_now    = tile_go && !in_handshake;

    assign entry_code   = mem.map_entry[CODE_W-1:0];
    assign entry_colour = mem.map_entry[CODE_W +: COLOR_W];
    assign entry_flip   = mem.map_entry[15] ^ flip_x_reg;
    assign cache_hit    = cache_valid_reg && ({entry_code, vfine_reg} == cache_base_reg);
    assign back_p0      = back_flip_reg ? back_words_reg[3:0] : back_words_reg[31:28];
    assign unused_entry_bits = ^mem.map_entry;

    // Words are kept as {word0, word1}; unflipped pixel i is nibble 7-i from
    // the bottom, flipped pixel i is nibble i.
    logic [PIX_W-1:0] front_lane [8];
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_lane
        assign front_lane[gi] = front_flip_reg ? front_words_reg[4*gi +: 4]
                                               : front_words_reg[28-4*gi +: 4];
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state_reg        <= IDLE;
            map_rd_reg       <= 1'b0;
            rom_req_reg      <= 1'b0;
            rom_addr_reg     <= '0;
            vfine_reg        <= '0;
            flip_x_reg       <= 1'b0;
            drain_reg        <= 1'b0;
            code_reg         <= '0;
            colour_reg       <= '0;
            flip_reg         <= 1'b0;
            word0_reg        <= '0;
            cache_valid_reg  <= 1'b0;
            cache_base_reg   <= '0;
            cache_words_reg  <= '0;
            back_words_reg   <= '0;
            back_colour_reg  <= '0;
            back_flip_reg    <= 1'b0;
            front_words_reg  <= '0;
            front_colour_reg <= '0;
            front_flip_reg   <= 1'b0;
            pix_idx_reg      <= 4'd8;
            pix_reg          <= '0;
            underrun_reg     <= 1'b0;
        end else begin
            map_rd_reg <= 1'b0;

            // ---------------- display side ----------------
            if (tile_go) begin
                pix_idx_reg <= 4'd1;
                if (state_reg == DONE) begin
                    front_words_reg  <= back_words_reg;
                    front_colour_reg <= back_colour_reg;
                    front_flip_reg   <= back_flip_reg;
                    pix_reg          <= {back_colour_reg, back_p0};
                end else begin
                    front_words_reg  <= '0;
                    front_colour_reg <= '0;
                    front_flip_reg   <= 1'b0;
                    pix_reg          <= '0;
                    // From IDLE nothing was in flight, so it is not late.
                    if (state_reg != IDLE) begin
                        underrun_reg <= 1'b1;
                    end
                end
            end else if (pix_cen) begin
                if (!pix_idx_reg[3]) begin
                    pix_reg     <= {front_colour_reg, front_lane[pix_idx_reg[2:0]]};
                    pix_idx_reg <= pix_idx_reg + 4'd1;
                end else begin
                    pix_reg <= {front_colour_reg, {PIX_W{1'b0}}};
                end
            end

            // ---------------- fetch side ----------------
            if (start_now) begin
                map_rd_reg <= 1'b1;
                vfine_reg  <= vfine;
                flip_x_reg <= flip_x;
                drain_reg  <= 1'b0;
                state_reg  <= MAPRD;
            end else begin
                case (state_reg)
                    MAPRD: state_reg <= MAPWAIT;

                    MAPWAIT: begin
                        code_reg   <= entry_code;
                        colour_reg <= entry_colour;
                        flip_reg   <= entry_flip;
                        if (cache_hit) begin
                            back_words_reg  <= cache_words_reg;
                            back_colour_reg <= entry_colour;
                            back_flip_reg   <= entry_flip;
                            state_reg       <= DONE;
                        end else begin
                            state_reg <= REQ0;
                        end
                    end

                    REQ0, REQ1: begin
                        if (!rom_req_reg) begin
                            // Raise the request one cycle after entering the
                            // state, so ROM_req is low for a cycle between words.
                            rom_req_reg  <= 1'b1;
                            rom_addr_reg <= {code_reg, vfine_reg, (state_reg == REQ1)};
                        end else begin
                            if (tile_go) begin
                                drain_reg  <= 1'b1;
                                vfine_reg  <= vfine;
                                flip_x_reg <= flip_x;
                            end
                            if (mem.ROM_ack) begin
                                rom_req_reg <= 1'b0;
                                if (drain_reg || tile_go) begin
                                    // Abandoned fetch: drop the data, start the
                                    // pending one.
                                    drain_reg  <= 1'b0;
                                    map_rd_reg <= 1'b1;
                                    state_reg  <= MAPRD;
                                end else if (state_reg == REQ0) begin
                                    word0_reg <= mem.ROM_data;
                                    state_reg <= REQ1;
                                end else begin
                                    cache_valid_reg <= 1'b1;
                                    cache_base_reg  <= {code_reg, vfine_reg};
                                    cache_words_reg <= {word0_reg, mem.ROM_data};
                                    back_words_reg  <= {word0_reg, mem.ROM_data};
                                    back_colour_reg <= colour_reg;
                                    back_flip_reg   <= flip_reg;
                                    state_reg       <= DONE;
                                end
                            end
                        end
                    end

                    default: ;  // IDLE and DONE wait for tile_start
                endcase
            end
        end
    end

    assign mem.map_rd   = map_rd_reg;
    assign mem.ROM_req  = rom_req_reg;
    assign mem.ROM_addr = rom_addr_reg;
    assign pix          = pix_reg;
    assign underrun     = underrun_reg;

endmodule

// File: tb/tb_xsleena_tile_fetch.sv
// ---------------------------------------------------------------------------
// tb_xsleena_tile_fetch
//   Directed bench: tilemap SRAM and ROM controller models, hand-computed
//   pixel sequences per tile, handshake protocol monitor.
// ---------------------------------------------------------------------------
module tb_xsleena_tile_fetch;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       pix_cen = 1'b0;
    logic       tile_start = 1'b0;
    logic [2:0] vfine = 3'd0;
    logic       flip_x = 1'b0;
    logic [6:0] pix;
    logic       underrun;

    logic [15:0] cur_entry = 16'h0000;
    logic        hold_all = 1'b0;
    logic        hold_odd = 1'b0;
    int          ack_count = 0;
    logic [13:0] ack_log [0:31];
    logic [2:0]  ack_cnt = 3'd0;
    int          proto_errs = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_rstn = 1'b0;
    logic [13:0] prev_addr = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xsleena_tile_fetch_if #(.ROM_AW(14)) bus ();

    xsleena_tile_fetch dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .pix_cen    (pix_cen),
        .tile_start (tile_start),
        .vfine      (vfine),
        .flip_x     (flip_x),
        .mem        (bus),
        .pix        (pix),
        .underrun   (underrun)
    );

    function automatic logic [15:0] rom_word(input logic [13:0] a);
        case (a)
            14'h1556: return 16'h1234;
            14'h1557: return 16'h5678;
            14'h0AA2: return 16'h9ABC;
            14'h0AA3: return 16'hDEF0;
            default:  return 16'hEEEE;
        endcase
    endfunction

    // Tilemap SRAM: data valid exactly one clk after map_rd, junk otherwise.
    always @(posedge clk) begin
        bus.map_entry <= bus.map_rd ? cur_entry : 16'hDEAD;
    end

    // ROM controller: ack four cycles after the request is seen.
    always @(posedge clk) begin
        if (!RSTn) begin
            bus.ROM_ack <= 1'b0;
            ack_cnt     <= 3'd0;
        end else if (bus.ROM_ack) begin
            bus.ROM_ack <= 1'b0;
            ack_cnt     <= 3'd0;
        end else if (bus.ROM_req && !(hold_all || (hold_odd && bus.ROM_addr[0]))) begin
            if (ack_cnt == 3'd3) begin
                bus.ROM_ack  <= 1'b1;
                bus.ROM_data <= rom_word(bus.ROM_addr);
                if (ack_count < 32) ack_log[ack_count] <= bus.ROM_addr;
                ack_count <= ack_count + 1;
            end else begin
                ack_cnt <= ack_cnt + 3'd1;
            end
        end
    end

    // Request must stay high with a stable address until acknowledged.
    always @(negedge clk) begin
        if (prev_rstn && prev_req && !prev_ack &&
            (!bus.ROM_req || bus.ROM_addr != prev_addr))
            proto_errs++;
        prev_req  = bus.ROM_req;
        prev_ack  = bus.ROM_ack;
        prev_addr = bus.ROM_addr;
        prev_rstn = RSTn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input logic [15:0] e, input logic [2:0] v, input logic fx);
        cur_entry = e;
        vfine     = v;
        flip_x    = fx;
    endtask

    // Play npix pixels (4 clks each), the first with tile_start; seq holds
    // the expected pixel nibbles p0..p7 from the top down.
    task automatic run_tile(input string tag, input int npix,
                            input logic [2:0] colour, input logic [31:0] seq);
        logic [31:0] s;
        logic [6:0]  exp;
        s = seq;
        for (int i = 0; i < npix; i++) begin
            pix_cen    = 1'b1;
            tile_start = (i == 0);
            tick();
            pix_cen    = 1'b0;
            tile_start = 1'b0;
            exp = (i < 8) ? {colour, s[31-4*i -: 4]} : {colour, 4'h0};
            check($sformatf("%s p%0d", tag, i), {25'd0, pix}, {25'd0, exp});
            repeat (3) tick();
        end
        $display("tile %s: %0d pixels, colour %0d, pattern %h, underrun %0b",
                 tag, npix, colour, seq, underrun);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // ---------------- reset ----------------
        repeat (3) tick();
        check("reset pix", {25'd0, pix}, 32'd0);
        check("reset underrun", {31'd0, underrun}, 32'd0);
        check("reset ROM_req", {31'd0, bus.ROM_req}, 32'd0);
        check("reset map_rd", {31'd0, bus.map_rd}, 32'd0);
        check("reset ROM_addr", {18'd0, bus.ROM_addr}, 32'd0);
        RSTn = 1'b1;
        tick();

        // ---------------- normal fetch ----------------
        set_tile(16'h2155, 3'd3, 1'b0);
        run_tile("T1", 9, 3'd0, 32'h0000_0000);
        check("T1 acks", ack_count, 2);
        check("T1 addr0", {18'd0, ack_log[0]}, 32'h1556);
        check("T1 addr1", {18'd0, ack_log[1]}, 32'h1557);
        check("T1 underrun", {31'd0, underrun}, 32'd0);

        // ---------------- cache hit, ready within 3 clks ----------------
        set_tile(16'h2155, 3'd3, 1'b0);
        run_tile("T2", 1, 3'd0, 32'h1234_5678);
        set_tile(16'hA155, 3'd3, 1'b0);
        run_tile("T3", 9, 3'd0, 32'h1234_5678);
        check("T3 underrun", {31'd0, underrun}, 32'd0);
        check("T3 acks", ack_count, 2);

        // ---------------- flips ----------------
        set_tile(16'hA155, 3'd3, 1'b1);
        run_tile("T4 flip", 9, 3'd0, 32'h8765_4321);
        check("T4 acks", ack_count, 2);
        set_tile(16'h14AA, 3'd1, 1'b0);
        run_tile("T5 dblflip", 9, 3'd0, 32'h1234_5678);
        check("T5 acks", ack_count, 4);
        check("T5 addr0", {18'd0, ack_log[2]}, 32'h0AA2);
        check("T5 addr1", {18'd0, ack_log[3]}, 32'h0AA3);

        // ---------------- colour ----------------
        set_tile(16'h2155, 3'd3, 1'b0);
        run_tile("T6 colour", 9, 3'd5, 32'h9ABC_DEF0);
        check("T6 acks", ack_count, 6);

        // ---------------- underrun ----------------
        hold_all = 1'b1;
        set_tile(16'h14AA, 3'd1, 1'b0);
        run_tile("T7", 1, 3'd0, 32'h1234_5678);
        repeat (2) tick();
        check("T7 req held", {31'd0, bus.ROM_req}, 32'd1);
        check("T7 req addr", {18'd0, bus.ROM_addr}, 32'h0AA2);
        set_tile(16'h2155, 3'd3, 1'b0);
        run_tile("T8 underrun", 9, 3'd0, 32'h0000_0000);
        check("T8 underrun", {31'd0, underrun}, 32'd1);
        check("T8 req held", {31'd0, bus.ROM_req}, 32'd1);
        check("T8 acks", ack_count, 6);
        hold_all = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ROM_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check("T8 ack seen", {31'd0, seen}, 32'd1);
        tick();
        check("T8 map_rd after ack", {31'd0, bus.map_rd}, 32'd1);
        check("T8 req dropped", {31'd0, bus.ROM_req}, 32'd0);
        repeat (12) tick();
        check("T8 acks after drain", ack_count, 7);
        set_tile(16'h2155, 3'd3, 1'b0);
        run_tile("T9 cache kept", 9, 3'd0, 32'h1234_5678);
        check("T9 acks", ack_count, 7);
        check("T9 underrun sticky", {31'd0, underrun}, 32'd1);

        // ---------------- reset mid-handshake ----------------
        hold_odd = 1'b1;
        set_tile(16'h14AA, 3'd1, 1'b0);
        run_tile("T10", 1, 3'd0, 32'h1234_5678);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ROM_req && bus.ROM_addr == 14'h0AA3) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("T10 req1 pending", {31'd0, seen}, 32'd1);
        RSTn = 1'b0;
        tick();
        check("rst2 ROM_req", {31'd0, bus.ROM_req}, 32'd0);
        check("rst2 pix", {25'd0, pix}, 32'd0);
        check("rst2 underrun", {31'd0, underrun}, 32'd0);
        check("rst2 ROM_addr", {18'd0, bus.ROM_addr}, 32'd0);
        tick();
        RSTn = 1'b1;
        hold_odd = 1'b0;
        tick();
        check("rst2 acks", ack_count, 8);

        set_tile(16'h2155, 3'd3, 1'b0);
        run_tile("T11 post-reset", 9, 3'd0, 32'h0000_0000);
        check("T11 acks", ack_count, 10);
        check("T11 addr0", {18'd0, ack_log[8]}, 32'h1556);
        check("T11 addr1", {18'd0, ack_log[9]}, 32'h1557);
        set_tile(16'h14AA, 3'd1, 1'b0);
        run_tile("T12", 9, 3'd0, 32'h1234_5678);

        check("protocol", proto_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
